simd_sfu_sched: RTL

Round-robin scheduler that shares the SIMD core's single special-function unit (MAC / EXP / sequential DIV) among the PE execution lanes. It sits between the per-lane request logic in the SIMD wrapper and the SFU datapath. It picks one requesting lane, drives the SFU operand select and start pulse, and waits for SFU completion under a watchdog. It then returns the result to the granted lane over a valid/ready handshake.

---
 rtl/simd_sfu_sched_pkg.sv | 23 ++
 rtl/simd_sfu_sched_if.sv | 46 ++++
 rtl/simd_sfu_sched_rr_arbiter.sv | 26 ++
 rtl/simd_sfu_sched.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/simd_sfu_sched_pkg.sv
// Shared types and helpers for the SIMD special-function-unit scheduler.
package simd_sfu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        WAIT,
        RESP,
        ERR
    } sched_state_e;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_MAC = 2'd1;
    localparam logic [1:0] OP_EXP = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned lane_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/simd_sfu_sched_if.sv
// Lane-side and SFU-side signals of the scheduler; master is the scheduler.
interface simd_sfu_sched_if
    import simd_sfu_sched_pkg::*;
#(
    parameter int unsigned NUM_LANES = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OP_W      = 2
);
    localparam int unsigned LANE_W = lane_w(NUM_LANES);

    logic                      cntl__sched__enable;
    logic                      cntl__sched__clear_err;
    logic [NUM_LANES-1:0]      lane__sched__req_valid;
    logic [NUM_LANES*OP_W-1:0] lane__sched__req_op;
    logic [NUM_LANES-1:0]      sched__lane__grant;
    logic [LANE_W-1:0]         sched__sfu__sel;
    logic [OP_W-1:0]           sched__sfu__op;
    logic                      sched__sfu__start;
    logic                      sfu__sched__complete;
    logic [DATA_W-1:0]         sfu__sched__result;
    logic                      sched__lane__rsp_valid;
    logic [LANE_W-1:0]         sched__lane__rsp_lane;
    logic [DATA_W-1:0]         sched__lane__rsp_data;
    logic                      lane__sched__rsp_ready;
    logic                      sched__cntl__idle;
    logic                      sched__cntl__error;

    modport master (
        input  cntl__sched__enable, cntl__sched__clear_err,
               lane__sched__req_valid, lane__sched__req_op,
               sfu__sched__complete, sfu__sched__result, lane__sched__rsp_ready,
        output sched__lane__grant, sched__sfu__sel, sched__sfu__op, sched__sfu__start,
               sched__lane__rsp_valid, sched__lane__rsp_lane, sched__lane__rsp_data,
               sched__cntl__idle, sched__cntl__error
    );

    modport slave (
        output cntl__sched__enable, cntl__sched__clear_err,
               lane__sched__req_valid, lane__sched__req_op,
               sfu__sched__complete, sfu__sched__result, lane__sched__rsp_ready,
        input  sched__lane__grant, sched__sfu__sel, sched__sfu__op, sched__sfu__start,
               sched__lane__rsp_valid, sched__lane__rsp_lane, sched__lane__rsp_data,
               sched__cntl__idle, sched__cntl__error
    );

endinterface

// File: rtl/simd_sfu_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module simd_rr_arbiter
    import simd_sfu_sched_pkg::*;
#(
    parameter int unsigned N = 32,
    localparam int unsigned IW = lane_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // Index arithmetic wraps naturally because N is a power of two.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!o_found && i_req[i_ptr + IW'(i)]) begin
                o_idx   = i_ptr + IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simd_sfu_sched.sv
// Shares the single SFU among the execution lanes: round-robin grant, start, watchdog wait, response.
module simd_sfu_sched
    import simd_sfu_sched_pkg::*;
#(
    parameter int unsigned NUM_LANES = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OP_W      = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic              clk,
    input logic              reset_poweron,
    simd_sfu_sched_if.master bus
);
    localparam int unsigned LANE_W = lane_w(NUM_LANES);
    localparam int unsigned WDOG_W = lane_w(TIMEOUT);

    sched_state_e         r_state,     w_state_nxt;
    logic [LANE_W-1:0]    r_ptr,       w_ptr_nxt;
    logic [LANE_W-1:0]    r_win,       w_win_nxt;
    logic [OP_W-1:0]      r_op,        w_op_nxt;
    logic [NUM_LANES-1:0] r_grant,     w_grant_nxt;
    logic                 r_start,     w_start_nxt;
    logic [WDOG_W-1:0]    r_wdog,      w_wdog_nxt;
    logic                 r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]    r_rsp_data,  w_rsp_data_nxt;
    logic                 r_idle,      w_idle_nxt;
    logic                 r_error,     w_error_nxt;

    logic [LANE_W-1:0]    w_arb_idx;
    logic                 w_arb_found;
    logic [OP_W-1:0]      w_arb_op;

    simd_rr_arbiter #(.N(NUM_LANES)) u_arb (
        .i_req   (bus.lane__sched__req_valid),
        .i_ptr   (r_ptr),
        .o_idx   (w_arb_idx),
        .o_found (w_arb_found)
    );

    assign w_arb_op = bus.lane__sched__req_op[w_arb_idx * OP_W +: OP_W];

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_op        <= '0;
            r_grant     <= '0;
            r_start     <= 1'b0;
            r_wdog      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_idle      <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_win       <= w_win_nxt;
            r_op        <= w_op_nxt;
            r_grant     <= w_grant_nxt;
            r_start     <= w_start_nxt;
            r_wdog      <= w_wdog_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_idle      <= w_idle_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // Winner is latched on the IDLE->ARB edge so grant/sel/op are visible throughout ARB.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_win_nxt       = r_win;
        w_op_nxt        = r_op;
        w_grant_nxt     = r_grant;
        w_start_nxt     = 1'b0;
        w_wdog_nxt      = r_wdog;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_idle_nxt      = r_idle;
        w_error_nxt     = r_error;

        case (r_state)
            IDLE: begin
                if (bus.cntl__sched__enable && w_arb_found) begin
                    w_state_nxt = ARB;
                    w_win_nxt   = w_arb_idx;
                    w_op_nxt    = w_arb_op;
                    w_grant_nxt = NUM_LANES'(1) << w_arb_idx;
                    w_idle_nxt  = 1'b0;
                end
            end
            ARB: begin
                if (r_op == OP_W'(OP_NOP)) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = '0;
                end else begin
                    w_state_nxt = START;
                    w_start_nxt = 1'b1;
                    w_wdog_nxt  = '0;
                end
            end
            START: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // Completion takes priority over the watchdog limit.
                if (bus.sfu__sched__complete) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = bus.sfu__sched__result;
                end else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ERR;
                    w_error_nxt = 1'b1;
                    w_grant_nxt = '0;
                end else begin
                    w_wdog_nxt = r_wdog + WDOG_W'(1);
                end
            end
            RESP: begin
                if (bus.lane__sched__rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_grant_nxt     = '0;
                    w_ptr_nxt       = r_win + LANE_W'(1);
                    w_idle_nxt      = 1'b1;
                end
            end
            ERR: begin
                if (bus.cntl__sched__clear_err) begin
                    w_state_nxt = IDLE;
                    w_error_nxt = 1'b0;
                    w_idle_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_idle_nxt  = 1'b1;
                w_error_nxt = 1'b0;
            end
        endcase
    end

    assign bus.sched__lane__grant     = r_grant;
    assign bus.sched__sfu__sel        = r_win;
    assign bus.sched__sfu__op         = r_op;
    assign bus.sched__sfu__start      = r_start;
    assign bus.sched__lane__rsp_valid = r_rsp_valid;
    assign bus.sched__lane__rsp_lane  = r_win;
    assign bus.sched__lane__rsp_data  = r_rsp_data;
    assign bus.sched__cntl__idle      = r_idle;
    assign bus.sched__cntl__error     = r_error;

endmodule
